ysyx_22041211_ifu: RTL and testbench

Multi-cycle instruction fetch unit that replaces the combinational DPI fetch feeding the decoder. It owns the PC and issues one read per instruction on an AXI4-Lite-style read channel (AR/R). It presents the fetched word plus its PC to the decode stage with a valid/ready handshake, then waits for the retiring stage to return the next PC. Only one instruction is in flight, with no speculation.

---
 rtl/ysyx_22041211_ifu.sv | 137 +++++++++++++
 tb/tb_ysyx_22041211_ifu.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_ifu.sv
// Multi-cycle fetch unit: owns the PC, one AR/R read per instruction.
// Optional YSYX_22041211_IFU_PERF_EN adds fetch / bus-wait counters.
module ysyx_22041211_ifu #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC = ADDR_LEN'(32'h80000000)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_LEN-1:0] araddr_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [DATA_LEN-1:0] rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rvalid_i,
  output logic                rready_o,
  output logic [DATA_LEN-1:0] inst_o,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  input  logic                next_pc_valid_i,
  input  logic [ADDR_LEN-1:0] next_pc_i,
`ifdef YSYX_22041211_IFU_PERF_EN
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_wait_cnt,
`endif
  output logic                fetch_err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_OUT,
    S_WAIT_PC
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_LEN-1:0] r_pc;
  logic [DATA_LEN-1:0] r_inst;
  logic                r_err;

  logic w_take_pc;
  logic w_mis;
  logic w_r_hs;

  assign w_mis  = |next_pc_i[1:0];
  assign w_r_hs = (r_state == S_R) & rvalid_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A misaligned target never reaches the bus: it is reported directly.
  always_comb begin
    w_next    = r_state;
    w_take_pc = 1'b0;
    unique case (r_state)
      S_IDLE: w_next = S_AR;
      S_AR: begin
        if (arready_i) w_next = S_R;
      end
      S_R: begin
        if (rvalid_i) w_next = S_OUT;
      end
      S_OUT: begin
        if (inst_ready_i && next_pc_valid_i) begin
          w_take_pc = 1'b1;
          w_next    = w_mis ? S_OUT : S_AR;
        end else if (inst_ready_i) begin
          w_next = S_WAIT_PC;
        end
      end
      S_WAIT_PC: begin
        if (next_pc_valid_i) begin
          w_take_pc = 1'b1;
          w_next    = w_mis ? S_OUT : S_AR;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc   <= RESET_PC;
      r_inst <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_take_pc) begin
        r_pc <= next_pc_i;
        if (w_mis) begin
          r_inst <= '0;
          r_err  <= 1'b1;
        end
      end
      if (w_r_hs) begin
        r_inst <= (rresp_i != 2'b00) ? '0 : rdata_i;
        r_err  <= (rresp_i != 2'b00);
      end
    end
  end

`ifdef YSYX_22041211_IFU_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_wait;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_fetch <= '0;
      r_perf_wait  <= '0;
    end else begin
      if (w_r_hs) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (r_state == S_AR || r_state == S_R)
        r_perf_wait <= r_perf_wait + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_wait_cnt  = r_perf_wait;
`endif

  assign araddr_o     = r_pc;
  assign arvalid_o    = (r_state == S_AR);
  assign rready_o     = (r_state == S_R);
  assign inst_o       = r_inst;
  assign pc_o         = r_pc;
  assign fetch_err_o  = r_err;
  assign inst_valid_o = (r_state == S_OUT);

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Bench for ysyx_22041211_ifu: memory model, scoreboard, vector table.
module tb_ysyx_22041211_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rvalid_i;
  logic        rready_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        next_pc_valid_i;
  logic [31:0] next_pc_i;
  logic        fetch_err_o;
`ifdef YSYX_22041211_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_wait_cnt;
`endif

  always #5 clk = ~clk;

  ysyx_22041211_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .araddr_o       (araddr_o),
    .arvalid_o      (arvalid_o),
    .arready_i      (arready_i),
    .rdata_i        (rdata_i),
    .rresp_i        (rresp_i),
    .rvalid_i       (rvalid_i),
    .rready_o       (rready_o),
    .inst_o         (inst_o),
    .pc_o           (pc_o),
    .inst_valid_o   (inst_valid_o),
    .inst_ready_i   (inst_ready_i),
    .next_pc_valid_i(next_pc_valid_i),
    .next_pc_i      (next_pc_i),
`ifdef YSYX_22041211_IFU_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt),
`endif
    .fetch_err_o    (fetch_err_o)
  );

  localparam logic [31:0] RST_PC = 32'h80000000;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_data = 32'h0;
  logic [1:0]  mem_resp = 2'b00;
  logic        pend;

  // Memory: rvalid rises one cycle after the AR handshake edge.
  always @(posedge clk) begin
    if (!rst) begin
      pend     <= 1'b0;
      rvalid_i <= 1'b0;
      rdata_i  <= 32'h0;
      rresp_i  <= 2'b00;
    end else if (arvalid_o && arready_i) begin
      pend <= 1'b1;
    end else if (pend && !rvalid_i) begin
      rvalid_i <= 1'b1;
      rdata_i  <= mem_data;
      rresp_i  <= mem_resp;
    end else if (rvalid_i && rready_o) begin
      rvalid_i <= 1'b0;
      pend     <= 1'b0;
    end
  end

  int          ar_cnt = 0;
  logic [31:0] last_ar = 32'h0;

  always @(negedge clk) begin
    if (rst === 1'b1 && arvalid_o && arready_i) begin
      ar_cnt  <= ar_cnt + 1;
      last_ar <= araddr_o;
    end
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [31:0] npc;
    logic [31:0] data;
    logic [1:0]  resp;
    bit          same;
    logic [31:0] exp_inst;
    logic        exp_err;
    bit          exp_ar;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    exp_t e;
    for (int i = 0; i < 50 && !inst_valid_o; i++) cyc();
    if (!inst_valid_o) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout got inst_valid 0 expected 1", name);
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: output with empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      chk({name, ".inst"}, inst_o, e.inst);
      chk({name, ".pc"}, pc_o, e.pc);
      chk({name, ".err"}, {31'h0, fetch_err_o}, {31'h0, e.err});
    end
  endtask

  task automatic handoff(input logic [31:0] npc, input bit same);
    inst_ready_i = 1'b1;
    if (same) begin
      next_pc_valid_i = 1'b1;
      next_pc_i       = npc;
    end
    cyc();
    inst_ready_i    = 1'b0;
    next_pc_valid_i = 1'b0;
    if (!same) begin
      chk("wait_pc.valid", {31'h0, inst_valid_o}, 32'h0);
      cyc();
      next_pc_valid_i = 1'b1;
      next_pc_i       = npc;
      cyc();
      next_pc_valid_i = 1'b0;
    end
  endtask

  vec_t vt[8];

  initial begin
    logic [31:0] h_inst;
    logic [31:0] h_pc;
    int          a0;

    vt[0] = '{32'h80000004, 32'h00000013, 2'b00, 1'b1,
              32'h00000013, 1'b0, 1'b1};
    vt[1] = '{32'h80000008, 32'hdeadbeef, 2'b10, 1'b0,
              32'h00000000, 1'b1, 1'b1};
    vt[2] = '{32'h8000000c, 32'h00a00093, 2'b00, 1'b1,
              32'h00a00093, 1'b0, 1'b1};
    vt[3] = '{32'h80000002, 32'h11111111, 2'b00, 1'b1,
              32'h00000000, 1'b1, 1'b0};
    vt[4] = '{32'h80000001, 32'h22222222, 2'b00, 1'b0,
              32'h00000000, 1'b1, 1'b0};
    vt[5] = '{32'hfffffffc, 32'h12345678, 2'b00, 1'b1,
              32'h12345678, 1'b0, 1'b1};
    vt[6] = '{32'h00000000, 32'h0000006f, 2'b01, 1'b0,
              32'h00000000, 1'b1, 1'b1};
    vt[7] = '{32'h80000004, 32'h00100073, 2'b00, 1'b1,
              32'h00100073, 1'b0, 1'b1};

    rst             = 1'b0;
    arready_i       = 1'b1;
    inst_ready_i    = 1'b0;
    next_pc_valid_i = 1'b0;
    next_pc_i       = 32'h0;
    repeat (3) cyc();

    chk("rst.pc", pc_o, RST_PC);
    chk("rst.araddr", araddr_o, RST_PC);
    chk("rst.inst", inst_o, 32'h0);
    chk("rst.arvalid", {31'h0, arvalid_o}, 32'h0);
    chk("rst.rready", {31'h0, rready_o}, 32'h0);
    chk("rst.ivalid", {31'h0, inst_valid_o}, 32'h0);
    chk("rst.err", {31'h0, fetch_err_o}, 32'h0);

    mem_data = 32'h00100073;
    mem_resp = 2'b00;
    sb.push_back('{32'h00100073, RST_PC, 1'b0});
    rst = 1'b1;
    cyc();
    chk("t1.arvalid", {31'h0, arvalid_o}, 32'h1);
    chk("t1.araddr", araddr_o, RST_PC);
    cyc();
    cyc();
    chk("t1.valid_c3", {31'h0, inst_valid_o}, 32'h0);
    cyc();
    chk("t1.valid_c4", {31'h0, inst_valid_o}, 32'h1);
    wait_valid("t1");

    h_inst = inst_o;
    h_pc   = pc_o;
    for (int i = 0; i < 3; i++) begin
      next_pc_valid_i = (i == 1);
      next_pc_i       = 32'h00001234;
      cyc();
      next_pc_valid_i = 1'b0;
      chk("t3.hold_valid", {31'h0, inst_valid_o}, 32'h1);
      chk("t3.hold_inst", inst_o, h_inst);
      chk("t3.hold_pc", pc_o, h_pc);
    end

    arready_i = 1'b0;
    mem_data  = 32'h00000297;
    sb.push_back('{32'h00000297, 32'h80000010, 1'b0});
    handoff(32'h80000010, 1'b1);
    chk("t3.arvalid", {31'h0, arvalid_o}, 32'h1);
    chk("t3.araddr", araddr_o, 32'h80000010);
    for (int i = 0; i < 5; i++) begin
      next_pc_valid_i = (i == 2);
      next_pc_i       = 32'h00005678;
      cyc();
      next_pc_valid_i = 1'b0;
      chk("t2.arvalid", {31'h0, arvalid_o}, 32'h1);
      chk("t2.araddr", araddr_o, 32'h80000010);
      chk("t2.rready", {31'h0, rready_o}, 32'h0);
    end
    arready_i = 1'b1;
    wait_valid("t2");

    foreach (vt[k]) begin
      mem_data = vt[k].data;
      mem_resp = vt[k].resp;
      a0       = ar_cnt;
      sb.push_back('{vt[k].exp_inst, vt[k].npc, vt[k].exp_err});
      handoff(vt[k].npc, vt[k].same);
      wait_valid($sformatf("vec%0d", k));
      chk($sformatf("vec%0d.ar_cnt", k), ar_cnt - a0,
          vt[k].exp_ar ? 32'd1 : 32'd0);
      if (vt[k].exp_ar)
        chk($sformatf("vec%0d.araddr", k), last_ar, vt[k].npc);
    end

    mem_data = 32'h00000533;
    mem_resp = 2'b00;
    handoff(32'h80000020, 1'b1);
    for (int i = 0; i < 20 && !(rvalid_i && rready_o); i++) cyc();
    chk("t6.rvalid_pending", {31'h0, rvalid_i && rready_o}, 32'h1);
    rst = 1'b0;
    cyc();
    chk("t6.pc", pc_o, RST_PC);
    chk("t6.araddr", araddr_o, RST_PC);
    chk("t6.inst", inst_o, 32'h0);
    chk("t6.arvalid", {31'h0, arvalid_o}, 32'h0);
    chk("t6.rready", {31'h0, rready_o}, 32'h0);
    chk("t6.ivalid", {31'h0, inst_valid_o}, 32'h0);
    chk("t6.err", {31'h0, fetch_err_o}, 32'h0);
    cyc();
    chk("t6.ivalid2", {31'h0, inst_valid_o}, 32'h0);
    a0 = ar_cnt;
    sb.push_back('{32'h00000533, RST_PC, 1'b0});
    rst = 1'b1;
    wait_valid("t6.restart");
    chk("t6.ar_cnt", ar_cnt - a0, 32'd1);
    chk("t6.ar_addr", last_ar, RST_PC);

    chk("sb.empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
